mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and write-back stage of the ARM-subset pipeline: drives the register file's write port. Takes EX/MEM control and data, performs data-memory load/store against a 64-word internal memory, and latches results into the MEM/WB pipeline register. Drives `result_wb`, `dest_wb` and `wb_en` straight into the register file's write-back inputs. Also exposes the registered destination for the hazard/forwarding logic.

## Interface

Parameters:
- `DEPTH`, 64: data-memory words, power of two.
- `BASE_ADDR`, 1024: byte address of memory word 0.

Ports:
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `freeze` in 1: hold MEM/WB register; suppress memory write.
- `wb_en_in` in 1: instruction writes a register.
- `mem_r_en_in` in 1: load.
- `mem_w_en_in` in 1: store.
- `alu_res_in` in 32: ALU result; byte address for load/store.
- `val_rm_in` in 32: store data.
- `dest_in` in 4: destination register index.
- `wb_en` out 1: registered write enable to register file.
- `dest_wb` out 4: registered destination index.
- `result_wb` out 32: write-back data.
- `mem_fault` out 1: registered out-of-range flag. Present only with `DMEM_BOUNDS_CHECK_EN`.

## Operation

- Word index = `(alu_res_in - BASE_ADDR) >> 2`, truncated to log2(`DEPTH`) bits. Bits [1:0] are ignored; no alignment fault.
- Memory read is combinational from the word index.
- Memory write happens on the rising edge when `mem_w_en_in`=1 and `freeze`=0: the word gets `val_rm_in`.
- The MEM/WB register captures on every rising edge with `freeze`=0:
  - `wb_en_q` <= `wb_en_in`
  - `mem_r_q` <= `mem_r_en_in`
  - `alu_q` <= `alu_res_in`
  - `mdata_q` <= memory read data
  - `dest_q` <= `dest_in`
- `result_wb` = `mem_r_q` ? `mdata_q` : `alu_q`. This is the only combinational output path.
- `wb_en`, `dest_wb` are the registered `wb_en_q`, `dest_q`.
- `mem_r_en_in`=1 and `mem_w_en_in`=1 together: the write is performed, and the captured read data is the old word (pre-write).
- `freeze`=1: all pipeline registers hold, no memory write, and outputs are unchanged. The register file keeps seeing the held `wb_en`, so the repeated write is idempotent.
- No state machine; the only state is the memory array plus the single-entry pipeline register.

## Timing

- Reset values:
  - All memory words 0.
  - `wb_en`=0, `dest_wb`=0, `result_wb`=0, `mem_fault`=0.
- Reset mid-operation: an asynchronous assert clears everything immediately. A store presented in the same cycle is lost.
- Latency: inputs valid in cycle n are visible on the outputs after rising edge n+1. The register file commits them on the falling edge within cycle n+1.
- Store in cycle n followed by load of the same address in cycle n+1: the load returns the stored value, because the write lands at edge n+1 before the combinational read.
- Wrap-around: an address outside the window aliases modulo `DEPTH` unless bounds checking is compiled in.

## Configuration

- `DMEM_BOUNDS_CHECK_EN` defined:
  - Range check: an access (`mem_r_en_in` or `mem_w_en_in`) is out of range when `alu_res_in` < `BASE_ADDR` or `alu_res_in` >= `BASE_ADDR`+4·`DEPTH`.
  - Out-of-range store: the write is suppressed.
  - Out-of-range load: captured data is 0.
  - `mem_fault` registers 1 alongside that instruction (same freeze/reset rules), else 0.
- Undefined: no range check, modulo aliasing, no `mem_fault` port.

## Test plan

- Reset check: assert `rst` mid-cycle -> outputs 0 immediately; load from 1024 afterwards returns 0.
- ALU pass-through: `wb_en_in`=1, `alu_res_in`=0x0000_00AB, `dest_in`=5, no mem -> next cycle `wb_en`=1, `dest_wb`=5, `result_wb`=0xAB.
- Store then load back-to-back: store 0xDEAD_BEEF to 1032, then load 1032 into r3 -> next cycle `result_wb`=0xDEAD_BEEF, `dest_wb`=3.
- Freeze: freeze for 3 cycles while presenting a store of 0x1234 to 1028 and a new `dest_in`=7 -> outputs hold prior values, and a later load of 1028 returns the old content.
- Simultaneous read and write: 1036 holds 0x11, then present load+store 0x22 -> `result_wb`=0x11; a subsequent load returns 0x22.
- Bounds, with macro defined: store 0x55 to 1024+256 -> `mem_fault`=1 and word 0 unchanged. Without the macro, the same store writes word 0, and a load of 1024 returns 0x55.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 64-word data memory plus the register feeding the register-file write port.
// Optional DMEM_BOUNDS_CHECK_EN adds an address range check and a registered mem_fault output.
module mem_wb_stage #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en,
  output logic [3:0]  dest_wb,
  output logic [31:0] result_wb
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        mem_fault
`endif
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic [31:0]   rdata_cap;
  logic          wr_en;

  logic          wb_en_q;
  logic          mem_r_q;
  logic [31:0]   alu_q;
  logic [31:0]   mdata_q;
  logic [3:0]    dest_q;

  // Low address bits are dropped; out-of-window addresses alias modulo DEPTH.
  assign offset = alu_res_in - BASE;
  assign idx    = AW'(offset >> 2);
  assign rdata  = mem[idx];

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;

  logic oob;
  logic fault_q;

  assign oob = (mem_r_en_in | mem_w_en_in) &
               ((alu_res_in < BASE) | ({1'b0, alu_res_in} >= LIMIT));
  assign wr_en     = mem_w_en_in & ~freeze & ~oob;
  assign rdata_cap = oob ? 32'd0 : rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (!freeze) begin
      fault_q <= oob;
    end
  end

  assign mem_fault = fault_q;
`else
  assign wr_en     = mem_w_en_in & ~freeze;
  assign rdata_cap = rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= val_rm_in;
    end
  end

  // Read data is sampled before the same-edge write lands, so load+store returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
      alu_q   <= '0;
      mdata_q <= '0;
      dest_q  <= '0;
    end else if (!freeze) begin
      wb_en_q <= wb_en_in;
      mem_r_q <= mem_r_en_in;
      alu_q   <= alu_res_in;
      mdata_q <= rdata_cap;
      dest_q  <= dest_in;
    end
  end

  assign wb_en     = wb_en_q;
  assign dest_wb   = dest_q;
  assign result_wb = mem_r_q ? mdata_q : alu_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan steps followed by random traffic
// against an array-based reference model (handles DMEM_BOUNDS_CHECK_EN when defined).
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        mem_fault;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] model_mem [64];
  logic        exp_wb;
  logic [3:0]  exp_dest;
  logic [31:0] exp_res;
  logic        exp_fault;

  mem_wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .wb_en_in    (wb_en_in),
    .mem_r_en_in (mem_r_en_in),
    .mem_w_en_in (mem_w_en_in),
    .alu_res_in  (alu_res_in),
    .val_rm_in   (val_rm_in),
    .dest_in     (dest_in),
    .wb_en       (wb_en),
    .dest_wb     (dest_wb),
    .result_wb   (result_wb)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .mem_fault   (mem_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    exp_wb    = 1'b0;
    exp_dest  = 4'd0;
    exp_res   = 32'd0;
    exp_fault = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wb_en"},     32'(wb_en),     32'(exp_wb));
    chk({tag, ".dest_wb"},   32'(dest_wb),   32'(exp_dest));
    chk({tag, ".result_wb"}, result_wb,      exp_res);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk({tag, ".mem_fault"}, 32'(mem_fault), 32'(exp_fault));
`endif
  endtask

  // One pipeline cycle: drive inputs, advance the model, clock, then compare.
  task automatic cyc(input string tag, input logic fr, input logic we, input logic mr,
                     input logic mw, input logic [31:0] alu, input logic [31:0] rm,
                     input logic [3:0] d);
    logic [31:0] word;
    logic [31:0] rd;
    logic        out_of_range;
    int          w;
    freeze      = fr;
    wb_en_in    = we;
    mem_r_en_in = mr;
    mem_w_en_in = mw;
    alu_res_in  = alu;
    val_rm_in   = rm;
    dest_in     = d;
    word = (alu - 32'd1024) / 32'd4;
    w    = int'(word % 32'd64);
    out_of_range = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    out_of_range = (mr || mw) && (longint'(alu) < 1024 || longint'(alu) >= 1024 + 4 * 64);
`endif
    rd = out_of_range ? 32'd0 : model_mem[w];
    if (!fr) begin
      exp_wb    = we;
      exp_dest  = d;
      exp_res   = mr ? rd : alu;
      exp_fault = out_of_range;
      if (mw && !out_of_range) model_mem[w] = rm;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    rst         = 1'b1;
    freeze      = 1'b0;
    wb_en_in    = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    alu_res_in  = 32'd0;
    val_rm_in   = 32'd0;
    dest_in     = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.wb_en", 32'(wb_en), 32'd0);
    chk("reset.dest_wb", 32'(dest_wb), 32'd0);
    chk("reset.result_wb", result_wb, 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("reset.mem_fault", 32'(mem_fault), 32'd0);
`endif
    rst = 1'b0;

    // ALU pass-through
    cyc("pass", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AB, 32'd0, 4'd5);
    chk("pass.k_wb", 32'(wb_en), 32'd1);
    chk("pass.k_dest", 32'(dest_wb), 32'd5);
    chk("pass.k_res", result_wb, 32'h0000_00AB);

    // Asynchronous reset mid-cycle; the store presented alongside is lost
    cyc("pre_rst", 1'b0, 1'b1, 1'b0, 1'b1, 32'd1040, 32'h0000_0066, 4'd9);
    freeze      = 1'b0;
    wb_en_in    = 1'b1;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b1;
    alu_res_in  = 32'd1024;
    val_rm_in   = 32'h0000_0077;
    dest_in     = 4'd4;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.wb_en", 32'(wb_en), 32'd0);
    chk("async_rst.dest_wb", 32'(dest_wb), 32'd0);
    chk("async_rst.result_wb", result_wb, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc("rst_load0", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    chk("rst_load0.k", result_wb, 32'd0);
    cyc("rst_load16", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd1);
    chk("rst_load16.k", result_wb, 32'd0);

    // Store then load back-to-back
    cyc("st_1032", 1'b0, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0);
    cyc("ld_1032", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd3);
    chk("ld_1032.k_res", result_wb, 32'hDEAD_BEEF);
    chk("ld_1032.k_dest", 32'(dest_wb), 32'd3);

    // Freeze holds outputs and blocks the store
    cyc("st_1028", 1'b0, 1'b0, 1'b0, 1'b1, 32'd1028, 32'h0000_CAFE, 4'd0);
    cyc("pre_frz", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'd0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      cyc("frz", 1'b1, 1'b1, 1'b0, 1'b1, 32'd1028, 32'h0000_1234, 4'd7);
      chk("frz.k_dest", 32'(dest_wb), 32'd2);
      chk("frz.k_res", result_wb, 32'h0000_0099);
    end
    cyc("ld_1028", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd6);
    chk("ld_1028.k", result_wb, 32'h0000_CAFE);

    // Simultaneous load and store returns the old word
    cyc("st_1036", 1'b0, 1'b0, 1'b0, 1'b1, 32'd1036, 32'h0000_0011, 4'd0);
    cyc("rw_1036", 1'b0, 1'b1, 1'b1, 1'b1, 32'd1036, 32'h0000_0022, 4'd8);
    chk("rw_1036.k", result_wb, 32'h0000_0011);
    cyc("ld_1036", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1036, 32'd0, 4'd8);
    chk("ld_1036.k", result_wb, 32'h0000_0022);

    // Store just past the window: aliases to word 0 or faults
    cyc("st_1280", 1'b0, 1'b0, 1'b0, 1'b1, 32'd1280, 32'h0000_0055, 4'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("st_1280.k_fault", 32'(mem_fault), 32'd1);
`endif
    cyc("ld_1024", 1'b0, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd10);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("ld_1024.k", result_wb, 32'd0);
    chk("ld_1024.k_fault", 32'(mem_fault), 32'd0);
`else
    chk("ld_1024.k", result_wb, 32'h0000_0055);
`endif

    // Random traffic, addresses straddling both edges of the window
    for (int i = 0; i < 400; i++) begin
      logic        fr;
      logic        we;
      logic        mr;
      logic        mw;
      logic [31:0] alu;
      logic [31:0] rm;
      logic [3:0]  d;
      fr  = ($urandom_range(0, 7) == 0);
      we  = 1'($urandom);
      mr  = 1'($urandom);
      mw  = ($urandom_range(0, 2) == 0);
      alu = (mr || mw) ? 32'($urandom_range(990, 1310)) : $urandom;
      rm  = $urandom;
      d   = 4'($urandom);
      cyc("rand", fr, we, mr, mw, alu, rm, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
